// File: rtl/prog_fetch_if.sv
// Program-load, run-control and fetch-output bundle for prog_fetch.
// master drives loads/run/jump feedback; slave is the fetch unit itself.
interface prog_fetch_if;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       run;
    logic [3:0] pc_count;
    logic [7:0] instr_o;
    logic [3:0] pc;
    logic       instr_valid;
    logic       busy;
    logic       halted;

    modport master (
        output load_en, load_addr, load_data, run, pc_count,
        input  instr_o, pc, instr_valid, busy, halted
    );

    modport slave (
        input  load_en, load_addr, load_data, run, pc_count,
        output instr_o, pc, instr_valid, busy, halted
    );
endinterface

// File: rtl/prog_fetch.sv
// 16x8 program store with a two-cycle FETCH/EXEC sequencer, jump feedback
// from the downstream decode stage, and a HLT opcode that parks the unit.
module prog_fetch (
    input  logic        clk,
    input  logic        rst_n,
    prog_fetch_if.slave bus
);
    localparam logic [7:0] HLT = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic       run_q;
    logic       mem_we;
    logic [7:0] mem_q [16];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // a pending load takes priority over starting execution
                if (bus.load_en) begin
                    mem_we = 1'b1;
                end else if (bus.run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = mem_q[pc_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (instr_q == HLT) begin
                    instr_d = '0;
                    state_d = S_HALT;
                end else begin
                    pc_d    = (bus.pc_count != '0) ? bus.pc_count : pc_q + 4'd1;
                    state_d = bus.run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: begin
                mem_we = bus.load_en;
                // restart needs run low then high; a run held high stays parked
                if (bus.run && !run_q) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            run_q   <= bus.run;
        end
    end

    // program store is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.instr_o     = instr_q;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = (state_q == S_EXEC);
    assign bus.busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign bus.halted      = (state_q == S_HALT);
endmodule

// File: tb/tb_prog_fetch.sv
// Self-checking bench for prog_fetch: directed scenarios with constant
// expectations plus randomized traffic against a behavioural model.
module tb_prog_fetch;
    logic clk = 1'b0;
    logic rst_n;
    prog_fetch_if bus ();

    prog_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  prog [16];

    // Behavioural model: what the unit is doing, derived from the rules.
    localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;
    int         m_mode = M_IDLE;
    int         m_pc = 0;
    logic [7:0] m_instr = 8'h00;
    logic       m_run_seen = 1'b0;
    logic [7:0] m_mem [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode     <= M_IDLE;
            m_pc       <= 0;
            m_instr    <= 8'h00;
            m_run_seen <= 1'b0;
        end else begin
            m_run_seen <= bus.run;
            case (m_mode)
                M_IDLE: begin
                    if (bus.load_en) m_mem[bus.load_addr] <= bus.load_data;
                    else if (bus.run) m_mode <= M_FETCH;
                end
                M_FETCH: begin
                    m_instr <= m_mem[m_pc];
                    m_mode  <= M_EXEC;
                end
                M_EXEC: begin
                    if (m_instr == 8'hFF) begin
                        m_instr <= 8'h00;
                        m_mode  <= M_HALT;
                    end else begin
                        m_pc   <= (bus.pc_count != 4'h0) ? int'(bus.pc_count) : (m_pc + 1) % 16;
                        m_mode <= bus.run ? M_FETCH : M_IDLE;
                    end
                end
                default: begin
                    if (bus.load_en) m_mem[bus.load_addr] <= bus.load_data;
                    if (bus.run && !m_run_seen) begin
                        m_pc   <= 0;
                        m_mode <= M_FETCH;
                    end
                end
            endcase
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.run      = 1'b0;
        bus.load_en  = 1'b0;
        bus.pc_count = 4'h0;
        bus.load_addr = 4'h0;
        bus.load_data = 8'h00;
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) begin
            bus.load_en   = 1'b1;
            bus.load_addr = 4'(i);
            bus.load_data = prog[i];
            cycle();
        end
        bus.load_en = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.load_en = 1'b0; bus.pc_count = 4'h0;
        bus.load_addr = 4'h0; bus.load_data = 8'h00;
        rst_n = 1'b0;
        #2;
        checks++; if (bus.pc !== 4'h0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", bus.pc); end
        checks++; if (bus.instr_o !== 8'h00) begin errors++; $display("FAIL reset_instr got=%0h exp=00", bus.instr_o); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_halt_sequence();
        do_reset();
        clear_prog();
        prog[0] = 8'h21; prog[1] = 8'h42; prog[2] = 8'hFF;
        load_all();
        bus.run = 1'b1;
        cycle();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL seq_fetch_busy got=%b exp=1", bus.busy); end
        cycle();
        checks++; if (bus.instr_o !== 8'h21) begin errors++; $display("FAIL seq_instr0 got=%0h exp=21", bus.instr_o); end
        checks++; if (bus.pc !== 4'h0) begin errors++; $display("FAIL seq_pc0 got=%0h exp=0", bus.pc); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid0 got=%b exp=1", bus.instr_valid); end
        cycle();
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL seq_fetch_valid got=%b exp=0", bus.instr_valid); end
        cycle();
        checks++; if (bus.instr_o !== 8'h42) begin errors++; $display("FAIL seq_instr1 got=%0h exp=42", bus.instr_o); end
        checks++; if (bus.pc !== 4'h1) begin errors++; $display("FAIL seq_pc1 got=%0h exp=1", bus.pc); end
        cycle();
        cycle();
        checks++; if (bus.pc !== 4'h2) begin errors++; $display("FAIL seq_pc2 got=%0h exp=2", bus.pc); end
        cycle();
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL seq_halted got=%b exp=1", bus.halted); end
        checks++; if (bus.pc !== 4'h2) begin errors++; $display("FAIL seq_halt_pc got=%0h exp=2", bus.pc); end
        checks++; if (bus.instr_o !== 8'h00) begin errors++; $display("FAIL seq_halt_instr got=%0h exp=00", bus.instr_o); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL seq_halt_busy got=%b exp=0", bus.busy); end
        repeat (3) cycle();
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL seq_halt_sticky got=%b exp=1", bus.halted); end
    endtask

    task automatic test_load_ignored();
        do_reset();
        clear_prog();
        prog[0] = 8'h21; prog[1] = 8'h42; prog[2] = 8'hFF;
        load_all();
        bus.run = 1'b1;
        cycle();
        bus.load_en = 1'b1; bus.load_addr = 4'h0; bus.load_data = 8'hAA;
        cycle();
        cycle();
        bus.load_en = 1'b0;
        for (int i = 0; i < 20 && !bus.halted; i++) cycle();
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL ign_reach_halt got=%b exp=1", bus.halted); end
        bus.run = 1'b0;
        cycle();
        bus.run = 1'b1;
        cycle();
        checks++; if (bus.pc !== 4'h0 || bus.busy !== 1'b1) begin errors++; $display("FAIL ign_restart pc=%0h busy=%b exp pc=0 busy=1", bus.pc, bus.busy); end
        cycle();
        checks++; if (bus.instr_o !== 8'h21) begin errors++; $display("FAIL ign_mem0 got=%0h exp=21", bus.instr_o); end
    endtask

    task automatic test_jump();
        do_reset();
        clear_prog();
        prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03; prog[3] = 8'h35;
        prog[9] = 8'h5A; prog[12] = 8'hC0; prog[10] = 8'hFF;
        load_all();
        bus.run = 1'b1;
        repeat (7) cycle();
        bus.pc_count = 4'hC;
        cycle();
        checks++; if (bus.instr_o !== 8'h35) begin errors++; $display("FAIL jmp_instr3 got=%0h exp=35", bus.instr_o); end
        checks++; if (bus.pc !== 4'h3) begin errors++; $display("FAIL jmp_ignored_in_fetch got=%0h exp=3", bus.pc); end
        bus.pc_count = 4'h9;
        cycle();
        checks++; if (bus.pc !== 4'h9) begin errors++; $display("FAIL jmp_pc got=%0h exp=9", bus.pc); end
        bus.pc_count = 4'h0;
        cycle();
        checks++; if (bus.instr_o !== 8'h5A || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL jmp_target instr=%0h valid=%b exp 5a/1", bus.instr_o, bus.instr_valid); end
        bus.pc_count = 4'h9;
        cycle();
        cycle();
        checks++; if (bus.pc !== 4'h9 || bus.instr_o !== 8'h5A) begin errors++; $display("FAIL jmp_self pc=%0h instr=%0h exp 9/5a", bus.pc, bus.instr_o); end
        bus.pc_count = 4'h0;
    endtask

    task automatic test_wrap();
        do_reset();
        clear_prog();
        prog[0] = 8'h10; prog[15] = 8'hE1;
        load_all();
        bus.run = 1'b1;
        cycle();
        cycle();
        bus.pc_count = 4'hF;
        cycle();
        checks++; if (bus.pc !== 4'hF) begin errors++; $display("FAIL wrap_pc15 got=%0h exp=f", bus.pc); end
        bus.pc_count = 4'h0;
        cycle();
        checks++; if (bus.instr_o !== 8'hE1) begin errors++; $display("FAIL wrap_instr15 got=%0h exp=e1", bus.instr_o); end
        cycle();
        checks++; if (bus.pc !== 4'h0) begin errors++; $display("FAIL wrap_pc0 got=%0h exp=0", bus.pc); end
        cycle();
        checks++; if (bus.instr_o !== 8'h10) begin errors++; $display("FAIL wrap_mem0 got=%0h exp=10", bus.instr_o); end
    endtask

    task automatic test_run_drop();
        do_reset();
        clear_prog();
        prog[0] = 8'h10; prog[5] = 8'h55; prog[6] = 8'h66;
        load_all();
        bus.run = 1'b1;
        cycle();
        cycle();
        bus.pc_count = 4'h5;
        cycle();
        bus.pc_count = 4'h0;
        cycle();
        checks++; if (bus.instr_o !== 8'h55 || bus.pc !== 4'h5) begin errors++; $display("FAIL drop_exec5 instr=%0h pc=%0h exp 55/5", bus.instr_o, bus.pc); end
        bus.run = 1'b0;
        cycle();
        checks++; if (bus.pc !== 4'h6) begin errors++; $display("FAIL drop_pc got=%0h exp=6", bus.pc); end
        checks++; if (bus.busy !== 1'b0 || bus.halted !== 1'b0) begin errors++; $display("FAIL drop_idle busy=%b halted=%b exp 0/0", bus.busy, bus.halted); end
        bus.load_en = 1'b1; bus.load_addr = 4'h6; bus.load_data = 8'hC3;
        cycle();
        bus.load_en = 1'b0;
        bus.run = 1'b1;
        cycle();
        cycle();
        checks++; if (bus.instr_o !== 8'hC3 || bus.pc !== 4'h6) begin errors++; $display("FAIL drop_newval instr=%0h pc=%0h exp c3/6", bus.instr_o, bus.pc); end
        bus.run = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        clear_prog();
        prog[0] = 8'h10; prog[7] = 8'h77;
        load_all();
        bus.run = 1'b1;
        cycle();
        cycle();
        bus.pc_count = 4'h7;
        cycle();
        bus.pc_count = 4'h0;
        cycle();
        checks++; if (bus.pc !== 4'h7 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL rmid_exec7 pc=%0h valid=%b exp 7/1", bus.pc, bus.instr_valid); end
        #2;
        rst_n = 1'b0;
        bus.run = 1'b0;
        #1;
        checks++; if (bus.pc !== 4'h0) begin errors++; $display("FAIL rmid_pc got=%0h exp=0", bus.pc); end
        checks++; if (bus.instr_o !== 8'h00) begin errors++; $display("FAIL rmid_instr got=%0h exp=00", bus.instr_o); end
        checks++; if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_flags valid=%b busy=%b exp 0/0", bus.instr_valid, bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.run = 1'b1;
        cycle();
        cycle();
        checks++; if (bus.instr_o !== 8'h10 || bus.pc !== 4'h0) begin errors++; $display("FAIL rmid_mem0 instr=%0h pc=%0h exp 10/0", bus.instr_o, bus.pc); end
        bus.pc_count = 4'h7;
        cycle();
        bus.pc_count = 4'h0;
        cycle();
        checks++; if (bus.instr_o !== 8'h77) begin errors++; $display("FAIL rmid_mem7 got=%0h exp=77", bus.instr_o); end
        bus.run = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 16; i++)
            prog[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        load_all();
        for (int c = 0; c < 600; c++) begin
            bus.run       = ($urandom_range(0, 9) != 0);
            bus.pc_count  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            bus.load_en   = ($urandom_range(0, 11) == 0);
            bus.load_addr = 4'($urandom_range(0, 15));
            bus.load_data = 8'($urandom);
            cycle();
            checks++; if (bus.pc !== 4'(m_pc)) begin errors++; $display("FAIL rnd_pc c=%0d got=%0h exp=%0h", c, bus.pc, m_pc); end
            checks++; if (bus.instr_o !== m_instr) begin errors++; $display("FAIL rnd_instr c=%0d got=%0h exp=%0h", c, bus.instr_o, m_instr); end
            checks++; if (bus.instr_valid !== (m_mode == M_EXEC)) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.instr_valid, m_mode == M_EXEC); end
            checks++; if (bus.busy !== (m_mode == M_FETCH || m_mode == M_EXEC)) begin errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.busy, m_mode == M_FETCH || m_mode == M_EXEC); end
            checks++; if (bus.halted !== (m_mode == M_HALT)) begin errors++; $display("FAIL rnd_halted c=%0d got=%b exp=%b", c, bus.halted, m_mode == M_HALT); end
        end
        bus.load_en = 1'b0;
        bus.run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_halt_sequence();
        test_load_ignored();
        test_jump();
        test_wrap();
        test_run_drop();
        test_reset_mid_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prog_fetch.md
PROG_FETCH -- requirements
Module: prog_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below with clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 load_en  input  1  program-write strobe; honoured only in IDLE or HALT.
REQ-005 load_addr  input  4  program memory write address.
REQ-006 load_data  input  8  program memory write data.
REQ-007 run  input  1  level; 1 = execute program, 0 = stop after current instruction.
REQ-008 pc_count  input  4  jump target returned by the downstream jump-decode stage; nonzero = jump taken, 0 = no jump.
REQ-009 instr_o  output  8  registered instruction presented to the jump-decode stage.
REQ-010 pc  output  4  current program counter.
REQ-011 instr_valid  output  1  high while instr_o holds a fetched instruction, in the EXEC cycle.
REQ-012 busy  output  1  high in FETCH and EXEC.
REQ-013 halted  output  1  high in HALT.

Function
REQ-014 Storage SHALL be a 16 x 8 register array; a write occurs on the clk edge when load_en=1 and state is IDLE or HALT; otherwise load_en is ignored.
REQ-015 The FSM SHALL have states IDLE, FETCH, EXEC and HALT.
REQ-016 IDLE -> FETCH when run=1 and load_en=0; if load_en=1 the block stays in IDLE and performs the write.
REQ-017 FETCH: instr_o <= mem[pc]; next state EXEC; one fetch takes exactly 1 cycle.
REQ-018 EXEC: instr_valid=1; instr_o is held stable; pc_count is sampled at the end of the cycle.
REQ-019 EXEC exit, when instr_o = 8'hFF (HLT): pc is unchanged, instr_o <= 0, and the next state is HALT.
REQ-020 EXEC exit, otherwise: pc <= pc_count if pc_count != 0, else pc <= pc + 1 modulo 16 (15 wraps to 0).
REQ-021 After EXEC (non-HLT), the next state is FETCH if run=1, else IDLE; a deassertion of run never aborts an instruction mid-way.
REQ-022 Throughput SHALL be one instruction per 2 cycles; a taken jump adds no extra cycles.
REQ-023 A jump target of 0 cannot be expressed; address 0 is reached only by reset, by pc wrap, or via HALT restart.
REQ-024 pc_count == pc (self-jump) SHALL loop indefinitely at the same address with no special handling.
REQ-025 HALT: the block leaves HALT only when run=0 is followed by run=1 (rising edge of run seen in HALT); it then sets pc <= 0 and goes to FETCH.
REQ-026 pc_count SHALL be ignored in every state other than EXEC.
REQ-027 Outputs busy, halted and instr_valid SHALL be decoded from the registered state only (glitch-free).

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, pc=0, instr_o=8'h00, instr_valid=0, busy=0, halted=0, and the captured run history cleared.
REQ-029 Program memory contents SHALL NOT be altered by reset.
REQ-030 A reset asserted in FETCH or EXEC SHALL discard the in-flight instruction; no pc update occurs.
REQ-031 After rst_n deasserts, the first FETCH occurs on the first edge with run=1 seen in IDLE.

Verification
REQ-032 Load mem[0..2]=8'h21,8'h42,8'hFF; set run=1 -> instr_o sequence 21,42; pc 0,1,2; then halted=1 with pc=2 and instr_o=00.
REQ-033 mem[3]=8'h35; in EXEC at pc=3, drive pc_count=4'h9 -> next FETCH reads mem[9], pc=9.
REQ-034 With pc=15, pc_count=0 and a non-HLT instruction -> pc wraps to 0 and mem[0] is fetched.
REQ-035 Drop run during EXEC at pc=5 -> pc becomes 6, state IDLE, busy=0; a load_en write to mem[6] now succeeds, and raising run fetches the new value.
REQ-036 Pulse rst_n low mid-EXEC at pc=7 -> instantly pc=0, instr_o=00, instr_valid=0; memory contents verified unchanged by readback fetches.
REQ-037 Load_en=1 during FETCH/EXEC with addr=0, data=8'hAA -> mem[0] is unchanged (verified after halt and restart).
